dbus_sram_responder: RTL

//  Responder end of the data bus: accepts dbus_req_t from the core's memory stage, returns dbus_resp_t.

---
 rtl/dbus_sram_responder_pkg.sv | 30 +++
 rtl/dbus_sram_responder_if.sv | 7 +
 rtl/dbus_sram_responder_stall_lfsr.sv | 13 +
 rtl/dbus_sram_responder.sv | 94 +++++++++
 4 files changed

// File: rtl/dbus_sram_responder_pkg.sv
// dbus_sram_responder_pkg: shared data-bus types, FSM states and byte-lane merge helper
package dbus_sram_responder_pkg;

    localparam int DBUS_LANES = 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dbus_resp_state_e;

    typedef struct packed {
        logic                  valid;
        logic [63:0]           addr;
        logic [2:0]            size;
        logic [DBUS_LANES-1:0] strobe;
        logic [63:0]           data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    function automatic logic [63:0] lane_merge(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [DBUS_LANES-1:0] strobe);
        logic [63:0] mask;
        for (int i = 0; i < DBUS_LANES; i++) mask[8*i +: 8] = {8{strobe[i]}};
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// dbus_sram_responder_if: dreq/dresp pair between core memory stage (master) and responder (slave)
interface dbus_sram_responder_if;
    dbus_sram_responder_pkg::dbus_req_t  dreq;
    dbus_sram_responder_pkg::dbus_resp_t dresp;
    modport master (output dreq, input dresp);
    modport slave (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder_stall_lfsr.sv
// dbus_sram_responder_stall_lfsr: 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, seeded 8'hA5
module dbus_sram_responder_stall_lfsr (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    // Free-running shift; taps at bits 8,6,5,4 of the polynomial
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= 8'hA5;
        else q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};

endmodule

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: fixed-latency byte-strobed SRAM window on the data bus (random extra stall with DBUS_RESP_STALL_EN)
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] ADDR_BASE = 64'h8000_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    dbus_sram_responder_if.slave        bus,
    output logic                        busy
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]    state;
    logic [7:0]    cnt;
    logic [7:0]    load;
    logic [1:0]    extra;
    logic [63:0]   addr_q;
    logic [63:0]   data_q;
    logic [7:0]    strobe_q;
    logic [63:0]   acc_addr;
    logic [63:0]   acc_data;
    logic [7:0]    acc_strobe;
    logic [63:0]   off;
    logic          in_win;
    logic          go_resp;
    logic [AW-1:0] idx;
    logic [63:0]   mem [DEPTH];
    logic          unused_size;

`ifdef DBUS_RESP_STALL_EN
    logic [7:0] lfsr;
    logic [5:0] unused_lfsr;
    dbus_sram_responder_stall_lfsr u_lfsr (.clk(clk), .reset(reset), .q(lfsr));
    assign extra       = lfsr[1:0];
    assign unused_lfsr = lfsr[7:2];
`else
    assign extra = 2'd0;
`endif

    // load = cycles between the sampling edge and the edge that enters RESP
    assign load        = 8'(LATENCY - 1) + {6'd0, extra};
    assign acc_addr    = state == S_IDLE ? bus.dreq.addr : addr_q;
    assign acc_data    = state == S_IDLE ? bus.dreq.data : data_q;
    assign acc_strobe  = state == S_IDLE ? bus.dreq.strobe : strobe_q;
    assign go_resp     = bus.dreq.valid && (state == S_IDLE ? load == 8'd0 : state == S_WAIT && cnt == 8'd0);
    assign off         = acc_addr - ADDR_BASE;
    assign in_win      = off < 64'(DEPTH) * 64'd8;
    assign idx         = off[AW+2:3];
    assign busy        = state != S_IDLE;
    assign unused_size = ^bus.dreq.size;

    // Request FSM: latch on sample, count down, present a one-cycle registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            strobe_q  <= '0;
            bus.dresp <= '0;
        end else begin
            bus.dresp.addr_ok <= go_resp;
            bus.dresp.data_ok <= go_resp;
            if (go_resp) bus.dresp.data <= in_win ? mem[idx] : '0;
            case (state)
                S_IDLE: if (bus.dreq.valid) begin
                    addr_q   <= bus.dreq.addr;
                    data_q   <= bus.dreq.data;
                    strobe_q <= bus.dreq.strobe;
                    state    <= load == 8'd0 ? S_RESP : S_WAIT;
                    cnt      <= load == 8'd0 ? 8'd0 : load - 8'd1;
                end
                S_WAIT: begin
                    state <= !bus.dreq.valid ? S_IDLE : cnt == 8'd0 ? S_RESP : S_WAIT;
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Byte-lane write commits only on the edge entering RESP; the response above reads the pre-write word
    always_ff @(posedge clk)
        if (go_resp && in_win && acc_strobe != 8'd0)
            mem[idx] <= lane_merge(mem[idx], acc_data, acc_strobe);

endmodule
